// File: rtl/spdif_pkg.sv
// spdif_pkg: constants and helpers shared by the S/PDIF transmitter and receiver.
//   - FSM state and channel enums
//   - raw preamble patterns B/M/W, first half-bit in bit 7
//   - slot indices inside a 32-slot subframe
//   - default consumer channel-status block (copy permitted, 48 kHz)
package spdif_pkg;

  typedef enum logic {
    ST_PRE  = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } chan_t;

  localparam int SUBFRAME_HB = 64;
  localparam int PRE_HB      = 8;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  localparam int SLOT_DATA = 4;
  localparam int SLOT_V    = 28;
  localparam int SLOT_U    = 29;
  localparam int SLOT_C    = 30;
  localparam int SLOT_P    = 31;

  // Bit 2: copy permitted; bit 25: sample-rate field value for 48 kHz.
  localparam logic [191:0] CSTAT_DEFAULT = (192'd1 << 2) | (192'd1 << 25);

  function automatic logic [7:0] preamble_sel(input logic first_frame, input chan_t ch);
    if (ch == CH_R) return PRE_W;
    return first_frame ? PRE_B : PRE_M;
  endfunction

  // A valid ack is exactly the one-hot code of the requested channel.
  function automatic logic ack_hit(input logic [1:0] ack, input chan_t ch);
    return ack == ((ch == CH_R) ? 2'b10 : 2'b01);
  endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// spdif_bmc_enc: biphase-mark half-bit generator with preamble injection.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_step            advance the line to the next half-bit this cycle
//   i_pre             next half-bit is a raw preamble half-bit
//   i_pre_start       next half-bit is the first of a preamble
//   i_pre_bit         raw (uninverted) preamble half-bit value
//   i_slot_start      next half-bit is the first half of a data slot
//   i_bit             data bit of the current slot
//   o_line            biphase-mark line level
module spdif_bmc_enc (
  input  logic clk,
  input  logic rst,
  input  logic i_step,
  input  logic i_pre,
  input  logic i_pre_start,
  input  logic i_pre_bit,
  input  logic i_slot_start,
  input  logic i_bit,
  output logic o_line
);

  logic r_line;
  logic r_inv;
  logic w_inv;

  // The inversion decision is taken from the level just before the preamble
  // and held for all 8 preamble half-bits.
  assign w_inv = i_pre_start ? r_line : r_inv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line <= 1'b0;
      r_inv  <= 1'b0;
    end else if (i_step) begin
      if (i_pre) begin
        r_inv  <= w_inv;
        r_line <= i_pre_bit ^ w_inv;
      end else if (i_slot_start || i_bit) begin
        r_line <= ~r_line;
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/spdif_tx.sv
// spdif_tx: S/PDIF (IEC 60958) biphase-mark transmitter.
// Ports:
//   clk         single clock
//   rst         asynchronous active-low reset
//   pop_o       one-cycle request for the sample of the following subframe
//   ack_i       sample valid, bit0 = left, bit1 = right
//   data_i      24-bit PCM sample, valid with ack_i
//   cstat_i     192-bit channel-status block, bit i in frame i
//   spdif_o     biphase-mark line output
//   block_o     one-cycle pulse at the start of frame 0 (B preamble)
//   underrun_o  one-cycle pulse when a subframe starts without a sample
// Build option: SPDIF_TX_CSTAT_EN takes the C bits from cstat_i, latched at
// each block start; otherwise cstat_i is ignored and CSTAT_DEFAULT is sent.
// Handshake: pop_o requests a sample for the channel after the current one;
// the first ack_i cycle carrying that channel's one-hot code latches data_i.
// Further acks until the next subframe boundary are dropped; an ack on the
// boundary cycle itself answers the request issued at that boundary.
module spdif_tx
  import spdif_pkg::*;
#(
  parameter int HALFBIT_DIV      = 8,
  parameter int FRAMES_PER_BLOCK = 192
) (
  input  logic         clk,
  input  logic         rst,
  output logic         pop_o,
  input  logic [1:0]   ack_i,
  input  logic [23:0]  data_i,
  input  logic [191:0] cstat_i,
  output logic         spdif_o,
  output logic         block_o,
  output logic         underrun_o
);

  localparam int DW = (HALFBIT_DIV > 1) ? $clog2(HALFBIT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(HALFBIT_DIV - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(FRAMES_PER_BLOCK - 1);

  logic          r_run;
  logic [DW-1:0] r_div;
  logic [5:0]    r_hb;
  state_t        r_state;
  logic [7:0]    r_frame;
  chan_t         r_ch;
  logic          r_full;
  logic [23:0]   r_buf;
  logic [31:0]   r_word;
  logic [7:0]    r_pat;
  logic          r_pop;
  logic          r_block;
  logic          r_underrun;

  logic          w_step;
  logic          w_boundary;
  logic [5:0]    w_hb_n;
  state_t        w_state_n;
  logic [7:0]    w_frame_n;
  chan_t         w_ch_n;
  chan_t         w_req_cur;
  chan_t         w_req_n;
  logic          w_block_n;
  logic [7:0]    w_pat_n;
  logic [23:0]   w_data;
  logic          w_c;
  logic          w_par;
  logic [31:0]   w_word_n;
  logic          w_pre_bit;
  logic          w_bit;

  assign w_step     = (r_div == DIV_LAST);
  // Before the first subframe the boundary is taken immediately, so the
  // first clock after reset starts frame 0 L.
  assign w_boundary = !r_run || (w_step && r_hb == 6'd63);
  assign w_hb_n     = w_boundary ? 6'd0 : (w_step ? r_hb + 6'd1 : r_hb);

  always_comb begin
    w_ch_n    = r_ch;
    w_frame_n = r_frame;
    if (!r_run) begin
      w_ch_n    = CH_L;
      w_frame_n = 8'd0;
    end else if (w_boundary) begin
      w_ch_n = (r_ch == CH_L) ? CH_R : CH_L;
      if (r_ch == CH_R) w_frame_n = (r_frame == FRAME_LAST) ? 8'd0 : r_frame + 8'd1;
    end
  end

  assign w_req_cur = (r_ch == CH_L) ? CH_R : CH_L;
  assign w_req_n   = (w_ch_n == CH_L) ? CH_R : CH_L;
  assign w_block_n = (w_frame_n == 8'd0) && (w_ch_n == CH_L);
  assign w_pat_n   = w_boundary ? preamble_sel(w_frame_n == 8'd0, w_ch_n) : r_pat;

`ifdef SPDIF_TX_CSTAT_EN
  logic [191:0] r_cstat;
  logic [191:0] w_cstat_src;
  // Frame 0 L is built on the same edge that latches the block, so it
  // reads cstat_i directly.
  assign w_cstat_src = w_block_n ? cstat_i : r_cstat;
  assign w_c         = w_cstat_src[w_frame_n];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_cstat <= '0;
    else if (w_boundary && w_block_n) r_cstat <= cstat_i;
  end
`else
  logic w_cstat_unused;
  assign w_cstat_unused = ^cstat_i;
  assign w_c            = CSTAT_DEFAULT[w_frame_n];
`endif

  assign w_data = r_full ? r_buf : 24'd0;
  assign w_par  = ^{w_data, ~r_full, w_c};

  // Word is indexed by slot number; slots 0-3 (preamble) stay zero.
  always_comb begin
    w_word_n                   = '0;
    w_word_n[SLOT_DATA +: 24]  = w_data;
    w_word_n[SLOT_V]           = ~r_full;
    w_word_n[SLOT_U]           = 1'b0;
    w_word_n[SLOT_C]           = w_c;
    w_word_n[SLOT_P]           = w_par;
  end

  // Two-state FSM: PRE covers half-bits 0-7, DATA covers 8-63.
  always_comb begin
    w_state_n = r_state;
    if (w_boundary)
      w_state_n = ST_PRE;
    else if (w_step && r_state == ST_PRE && r_hb == 6'(PRE_HB - 1))
      w_state_n = ST_DATA;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_PRE;
    else      r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run      <= 1'b0;
      r_div      <= '0;
      r_hb       <= 6'd0;
      r_frame    <= 8'd0;
      r_ch       <= CH_L;
      r_full     <= 1'b0;
      r_buf      <= 24'd0;
      r_word     <= 32'd0;
      r_pat      <= 8'd0;
      r_pop      <= 1'b0;
      r_block    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_div      <= (w_boundary || w_step) ? '0 : r_div + 1'b1;
      r_hb       <= w_hb_n;
      r_frame    <= w_frame_n;
      r_ch       <= w_ch_n;
      r_pat      <= w_pat_n;
      r_pop      <= w_boundary;
      r_block    <= w_boundary && w_block_n;
      r_underrun <= w_boundary && !r_full;
      if (w_boundary) begin
        r_word <= w_word_n;
        r_full <= ack_hit(ack_i, w_req_n);
        if (ack_hit(ack_i, w_req_n)) r_buf <= data_i;
      end else if (!r_full && ack_hit(ack_i, w_req_cur)) begin
        r_full <= 1'b1;
        r_buf  <= data_i;
      end
    end
  end

  assign w_pre_bit = w_pat_n[3'd7 - w_hb_n[2:0]];
  assign w_bit     = r_word[w_hb_n[5:1]];

  spdif_bmc_enc u_bmc (
    .clk          (clk),
    .rst          (rst),
    .i_step       (w_boundary || w_step),
    .i_pre        (w_state_n == ST_PRE),
    .i_pre_start  (w_boundary),
    .i_pre_bit    (w_pre_bit),
    .i_slot_start (~w_hb_n[0]),
    .i_bit        (w_bit),
    .o_line       (spdif_o)
  );

  assign pop_o      = r_pop;
  assign block_o    = r_block;
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_spdif_tx.sv
module tb_spdif_tx;

  localparam int DIV = 2;
  localparam int FPB = 32;
  localparam int SF  = 64 * DIV;
  localparam int BLK = 2 * FPB * SF;
  localparam int RST_T = 129 * SF + 30 * DIV;
  localparam int CSTAT_CHG_T = 40 * SF + 37;
  localparam logic [7:0] P_B = 8'b1110_1000;
  localparam logic [7:0] P_M = 8'b1110_0010;
  localparam logic [7:0] P_W = 8'b1110_0100;

  // clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         pop_o;
  logic [1:0]   ack_i;
  logic [23:0]  data_i;
  logic [191:0] cstat_i;
  logic         spdif_o;
  logic         block_o;
  logic         underrun_o;

  always #5 clk = ~clk;

  spdif_tx #(.HALFBIT_DIV(DIV), .FRAMES_PER_BLOCK(FPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .pop_o      (pop_o),
    .ack_i      (ack_i),
    .data_i     (data_i),
    .cstat_i    (cstat_i),
    .spdif_o    (spdif_o),
    .block_o    (block_o),
    .underrun_o (underrun_o)
  );

  // scoreboard state
  int           n_checks = 0;
  int           n_fail   = 0;
  int           t;
  logic         run_a;
  logic [24:0]  exp_q[$];
  logic         pend_full;
  logic [23:0]  pend_data;
  logic         prev_level;
  logic [63:0]  hb_buf;
  logic [191:0] cstat_drv;
  logic [191:0] blk_cstat;
  int           n_acks;
  int           p_off[2];
  logic [1:0]   p_code[2];
  logic [23:0]  p_dat[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic exp_cbit(input int frame);
`ifdef SPDIF_TX_CSTAT_EN
    return blk_cstat[frame];
`else
    return (frame == 2) || (frame == 25);
`endif
  endfunction

  task automatic start_run();
    exp_q.delete();
    exp_q.push_back(25'd0);
    pend_full  = 1'b0;
    pend_data  = 24'd0;
    prev_level = 1'b0;
    n_acks     = 0;
    t          = 0;
  endtask

  task automatic decode(input int k);
    logic [7:0]  pre;
    logic [7:0]  epre;
    logic [27:0] w;
    logic [27:0] ew;
    logic [24:0] e;
    logic [23:0] d;
    logic        v;
    logic        c;
    int          viol;
    int          frame;
    frame = (k / 2) % FPB;
    for (int i = 0; i < 8; i++) pre[7-i] = hb_buf[i];
    viol = 0;
    for (int s = 4; s < 32; s++) begin
      if (hb_buf[2*s] == hb_buf[2*s-1]) viol++;
      w[s-4] = hb_buf[2*s] ^ hb_buf[2*s+1];
    end
    epre = ((k % 2) == 1) ? P_W : ((frame == 0) ? P_B : P_M);
    epre = epre ^ {8{prev_level}};
    if (exp_q.size() == 0) e = 25'h1ffffff;
    else e = exp_q.pop_front();
    d  = e[24] ? e[23:0] : 24'd0;
    v  = ~e[24];
    c  = exp_cbit(frame);
    ew = {^{d, v, c}, c, 1'b0, v, d};
    check_eq("preamble", 64'(pre), 64'(epre));
    check_eq("subframe_word", 64'(w), 64'(ew));
    check_eq("bmc_slot_edges", 64'(viol), 64'd0);
    prev_level = hb_buf[63];
  endtask

  // driver
  task automatic make_plan(input int k);
    logic [1:0] right;
    logic [1:0] wrong;
    int         r;
    right  = (((k + 1) % 2) == 1) ? 2'b10 : 2'b01;
    wrong  = ~right;
    n_acks = 0;
    if (run_a && k < 4) begin
      n_acks = 0;
    end else if (run_a && k < 12) begin
      n_acks = 1; p_off[0] = 10; p_code[0] = right;
      p_dat[0] = (right == 2'b10) ? 24'h7FFFFF : 24'h800001;
    end else if (run_a && k < 16) begin
      n_acks = 2;
      p_off[0] = 10; p_code[0] = wrong; p_dat[0] = 24'($urandom);
      p_off[1] = 20; p_code[1] = right; p_dat[1] = 24'($urandom);
    end else if (run_a && k < 20) begin
      n_acks = 2;
      p_off[0] = 10; p_code[0] = right; p_dat[0] = 24'($urandom);
      p_off[1] = 30; p_code[1] = right; p_dat[1] = 24'($urandom);
    end else if (run_a && k < 24) begin
      n_acks = 2;
      p_off[0] = 10; p_code[0] = 2'b11; p_dat[0] = 24'($urandom);
      p_off[1] = 40; p_code[1] = right; p_dat[1] = 24'($urandom);
    end else if (run_a && k < 28) begin
      // ack on the boundary cycle answers the request made at that boundary
      n_acks = 1; p_off[0] = SF - 1; p_dat[0] = 24'($urandom);
      p_code[0] = ((k % 2) == 1) ? 2'b10 : 2'b01;
    end else if (run_a && k == 129) begin
      n_acks = 1; p_off[0] = 10; p_code[0] = right; p_dat[0] = 24'($urandom);
    end else begin
      n_acks = $urandom_range(0, 2);
      p_off[0] = $urandom_range(0, SF/2 - 1);
      p_off[1] = $urandom_range(SF/2, SF - 1);
      for (int i = 0; i < 2; i++) begin
        r = $urandom_range(0, 5);
        p_code[i] = (r <= 2) ? right : (r == 3) ? wrong : (r == 4) ? 2'b11 : 2'b00;
        p_dat[i]  = 24'($urandom);
      end
    end
  endtask

  task automatic cycle_body();
    int          k;
    int          o;
    int          h;
    int          j;
    logic [2:0]  exp_pulse;
    logic        exp_full;
    k = t / SF;
    o = t % SF;
    h = o / DIV;
    if (t % BLK == 0) blk_cstat = cstat_drv;
    // pulses
    exp_full  = (exp_q.size() > 0) ? exp_q[0][24] : 1'b0;
    exp_pulse = {o == 0, (t % BLK) == 0, (o == 0) && !exp_full};
    check_eq("pop_block_underrun", 64'({pop_o, block_o, underrun_o}), 64'(exp_pulse));
    // line monitor
    if (o % DIV == 0) begin
      hb_buf[h] = spdif_o;
      if (h == 63) decode(k);
    end
    // drive inputs for this cycle
    if (o == 0) make_plan(k);
    ack_i  = 2'b00;
    data_i = 24'($urandom);
    for (int i = 0; i < n_acks; i++)
      if (p_off[i] == o) begin
        ack_i  = p_code[i];
        data_i = p_dat[i];
      end
    if (run_a && t == CSTAT_CHG_T) cstat_drv = {24{8'h5A}};
    cstat_i = cstat_drv;
    // reference model: each request window closes the cycle before a boundary
    if ((t + 1) % SF == 0) begin
      exp_q.push_back({pend_full, pend_data});
      pend_full = 1'b0;
      pend_data = 24'd0;
    end
    j = (t + 1) / SF + 1;
    if (!pend_full && ack_i == (((j % 2) == 1) ? 2'b10 : 2'b01)) begin
      pend_full = 1'b1;
      pend_data = data_i;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cycle_body();
      t++;
    end
  endtask

  initial begin
    rst       = 1'b0;
    ack_i     = 2'b00;
    data_i    = 24'd0;
    cstat_drv = {24{8'hA5}};
    cstat_i   = cstat_drv;
    blk_cstat = cstat_drv;
    t         = -1;
    repeat (3) @(negedge clk);
    check_eq("rst_spdif", 64'(spdif_o), 64'd0);
    check_eq("rst_pop", 64'(pop_o), 64'd0);
    check_eq("rst_block", 64'(block_o), 64'd0);
    check_eq("rst_underrun", 64'(underrun_o), 64'd0);

    // run A: two full blocks, directed then random acks
    rst   = 1'b1;
    run_a = 1'b1;
    start_run();
    run_cycles(RST_T);

    // reset at half-bit 30 of an R subframe holding a buffered L sample
    @(negedge clk);
    rst   = 1'b0;
    ack_i = 2'b00;
    #1;
    check_eq("midrst_outs", 64'({spdif_o, pop_o, block_o, underrun_o}), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_hold", 64'({spdif_o, pop_o, block_o, underrun_o}), 64'd0);
    end
    @(negedge clk);
    rst   = 1'b1;
    run_a = 1'b0;
    start_run();
    run_cycles(12 * SF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spdif_tx.md
SPDIF_TX -- requirements
Module: spdif_tx

Interface
REQ-001 SHALL have parameter HALFBIT_DIV, default 8, meaning clk cycles per biphase half-bit (8 at 49.152 MHz gives 48 kHz).
REQ-002 SHALL have parameter FRAMES_PER_BLOCK, default 192, meaning frames per channel-status block.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic runs in this clock domain.
REQ-004 SHALL have port rst, input, 1, meaning reset; it is asynchronous and active-low.
REQ-005 SHALL have port pop_o, output, 1, meaning a one-cycle request for the next sample.
REQ-006 SHALL have port ack_i, input, 2, meaning sample valid: bit0 = left, bit1 = right.
REQ-007 SHALL have port data_i, input, 24, meaning signed PCM sample, valid when ack_i is nonzero.
REQ-008 SHALL have port cstat_i, input, 192, meaning the channel-status block (bit i goes in frame i).
REQ-009 SHALL have port spdif_o, output, 1, meaning the biphase-mark line output.
REQ-010 SHALL have port block_o, output, 1, meaning a one-cycle pulse at the start of frame 0 (B preamble).
REQ-011 SHALL have port underrun_o, output, 1, meaning a one-cycle pulse when a subframe is sent without a sample.

Function
REQ-012 SHALL send subframes of 32 slots (64 half-bits, 64*HALFBIT_DIV cycles) in order L,R,L,R...; a frame is one L plus one R subframe.
REQ-013 SHALL fill slots as follows:
- 0-3: preamble.
- 4-27: data_i, LSB first.
- 28: V.
- 29: U=0.
- 30: C = channel-status bit of the current frame index.
- 31: P, even parity over slots 4-31.
REQ-014 SHALL encode slots 4-31 biphase-mark: a transition at every slot start, plus a mid-slot transition when the bit is 1.
REQ-015 SHALL send the preamble as 8 raw half-bits: B=11101000 (frame 0 L), M=11100010 (other L), W=11100100 (R); all 8 SHALL be inverted when spdif_o is 1 before the preamble.
REQ-016 SHALL use a state machine with two states: PRE (8 half-bits) and DATA (56 half-bits); PRE to DATA after half-bit 7; DATA to PRE after half-bit 63, which is also the subframe boundary.
REQ-017 SHALL assert pop_o for exactly one cycle, on the first clk of each subframe, requesting the sample for the following subframe; the requested channel is the opposite of the current subframe's channel.
REQ-018 SHALL latch data_i into a one-entry buffer on the first ack_i cycle whose bit matches the requested channel, before the next boundary; a second ack, a wrong-channel ack, or ack_i=11 SHALL be ignored.
REQ-019 SHALL load the buffer into the shift register at each boundary, giving a latency of exactly one subframe from ack to transmission.
REQ-020 SHALL handle an empty buffer at a boundary as follows: send data=0 with V=1, and pulse underrun_o on the same cycle. Otherwise V=0.
REQ-021 SHALL treat an ack arriving on the boundary cycle itself as belonging to the next request.
REQ-022 SHALL wrap the frame counter at FRAMES_PER_BLOCK-1 back to 0.
REQ-023 SHALL latch cstat_i into an internal 192-bit register when block_o pulses, so changes mid-block take effect at the next block.

Reset
REQ-024 SHALL, while rst=0, hold spdif_o=0, pop_o=0, block_o=0, underrun_o=0, state=PRE, frame=0, channel=L, half-bit counter=0, buffer empty and latched cstat=0.
REQ-025 SHALL, on the first clk after rst deasserts, start frame 0 L with preamble B: block_o=1, pop_o=1, underrun_o=1 and V=1 (the buffer is empty).
REQ-026 SHALL, when reset is asserted mid-subframe, abort the subframe immediately and restart per REQ-025.

Configuration
REQ-027 SHALL, with SPDIF_TX_CSTAT_EN defined, take C bits from the latched cstat_i; without it, cstat_i SHALL be ignored and C SHALL come from the package constant (all zero except bits 2 and 25: consumer, copy permitted, 48 kHz).

Structure
REQ-028 SHALL place the preamble constants (B/M/W), the default channel-status constant, and the slot indices (data start, V, U, C, P) in package spdif_pkg, shared with the receiver.
REQ-029 SHALL place the biphase-mark half-bit generator, including preamble injection and level tracking, in sub-module spdif_bmc_enc.

Verification
REQ-030 SHALL check: release reset with no acks -> block_o at cycle 0; underrun_o every 512 cycles; V=1 and data=0 in every subframe.
REQ-031 SHALL check: L=0x800001, R=0x7FFFFF acked 10 cycles after each pop -> decoded subframes carry those values with V=0 and correct P, and the left sample appears in the subframe after its ack.
REQ-032 SHALL check: ack with the wrong channel, then the right one -> only the second is sent; a double ack -> the first value is sent.
REQ-033 SHALL check 2 blocks -> block_o every 192*1024 cycles; B only on frame 0; M and W elsewhere; preamble polarity follows the prior level.
REQ-034 SHALL check, with SPDIF_TX_CSTAT_EN defined, cstat_i=0xA5 repeated, changed mid-block -> C bits follow the old value until the next block_o; without the macro, only C bits 2 and 25 are 1.
REQ-035 SHALL check rst pulsed at half-bit 30 of an R subframe -> outputs are 0 during reset, and transmission restarts with preamble B with no stale sample.
